branch_seq: RTL and testbench

- Control-side sequencer for conditional branches (brzr/brnz/brpl/brmi).
- Drives the condition-register strobe (con_in) and the Ra bus select, then samples the registered condition result (con_out).
- If the condition holds, computes and loads the branch target PC.
- Sits between the control unit's instruction decode and the PC register.
- It is the consumer end of the condition flip-flop interface: it produces the capture strobe and consumes the stored result.

---
 rtl/branch_seq_pkg.sv | 32 +++
 rtl/branch_seq_branch_target_adder.sv | 14 +
 rtl/branch_seq.sv | 136 +++++++++++++
 tb/tb_branch_seq.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/branch_seq_pkg.sv
// Shared types and field positions for the conditional-branch sequencer.
package branch_seq_pkg;

    localparam int unsigned WIDTH_DEF = 32;
    localparam int unsigned OFF_W_DEF = 19;
    localparam int unsigned C2_HI     = 22;
    localparam int unsigned C2_LO     = 19;
    localparam int unsigned C2_W      = C2_HI - C2_LO + 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DRIVE = 3'd1,
        ST_EVAL  = 3'd2,
        ST_TAKE  = 3'd3,
        ST_FIN   = 3'd4
    } state_t;

    typedef enum logic [C2_W-1:0] {
        C2_ZERO    = 4'd0,
        C2_NONZERO = 4'd1,
        C2_POS     = 4'd2,
        C2_NEG     = 4'd3
    } c2_code_t;

    // Register-file / condition-FF control strobes issued during DRIVE.
    typedef struct packed {
        logic gra;
        logic r_out;
        logic con_in;
    } bus_ctl_t;

endpackage

// File: rtl/branch_seq_branch_target_adder.sv
// Branch target: PC plus sign-extended displacement, wrapping modulo 2^WIDTH.
module branch_target_adder #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned OFF_W = 19
) (
    input  logic [WIDTH-1:0] pc,
    input  logic [OFF_W-1:0] disp,
    output logic [WIDTH-1:0] target_c
);

    // Casting the signed displacement to WIDTH replicates its sign bit.
    assign target_c = pc + WIDTH'($signed(disp));

endmodule

// File: rtl/branch_seq.sv
// Conditional-branch sequencer: strobes the condition FF, samples its result
// and loads the branch target into the PC when the condition holds.
module branch_seq
    import branch_seq_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned OFF_W = OFF_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [WIDTH-1:0]  ir,
    input  logic [WIDTH-1:0]  pc,
    input  logic              con_out,
    output logic [C2_W-1:0]   c2_sel,
    output logic              gra,
    output logic              r_out,
    output logic              con_in,
    output logic [WIDTH-1:0]  pc_next,
    output logic              pc_load,
    output logic              busy,
    output logic              done,
    output logic              taken
);

    state_t             state_q, state_d;
    logic [OFF_W-1:0]   disp_q, disp_d;
    logic [WIDTH-1:0]   pc_q, pc_d;
    logic [C2_W-1:0]    c2_sel_q, c2_sel_d;
    bus_ctl_t           ctl_q, ctl_d;
    logic [WIDTH-1:0]   pc_next_q, pc_next_d;
    logic               pc_load_q, pc_load_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               taken_q, taken_d;
    logic [WIDTH-1:0]   target_c;
    logic               unused_ir_c;

    // Only the C2 and displacement fields of ir matter here.
    assign unused_ir_c = ^ir;

    branch_target_adder #(
        .WIDTH (WIDTH),
        .OFF_W (OFF_W)
    ) u_target (
        .pc       (pc_q),
        .disp     (disp_q),
        .target_c (target_c)
    );

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            disp_q    <= '0;
            pc_q      <= '0;
            c2_sel_q  <= '0;
            ctl_q     <= '0;
            pc_next_q <= '0;
            pc_load_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            taken_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            disp_q    <= disp_d;
            pc_q      <= pc_d;
            c2_sel_q  <= c2_sel_d;
            ctl_q     <= ctl_d;
            pc_next_q <= pc_next_d;
            pc_load_q <= pc_load_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            taken_q   <= taken_d;
        end
    end

    // Next state; outputs are computed for the state being entered.
    always_comb begin
        state_d   = state_q;
        disp_d    = disp_q;
        pc_d      = pc_q;
        c2_sel_d  = c2_sel_q;
        ctl_d     = '0;
        pc_next_d = pc_next_q;
        pc_load_d = 1'b0;
        done_d    = 1'b0;
        taken_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_DRIVE;
                    disp_d   = ir[OFF_W-1:0];
                    pc_d     = pc;
                    c2_sel_d = ir[C2_HI:C2_LO];
                    ctl_d    = '{gra: 1'b1, r_out: 1'b1, con_in: 1'b1};
                end
            end
            ST_DRIVE: begin
                state_d   = ST_EVAL;
                pc_next_d = target_c;
            end
            ST_EVAL: begin
                done_d = 1'b1;
                if (con_out) begin
                    state_d   = ST_TAKE;
                    pc_load_d = 1'b1;
                    taken_d   = 1'b1;
                end else begin
                    state_d = ST_FIN;
                end
            end
            ST_TAKE,
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    assign c2_sel  = c2_sel_q;
    assign gra     = ctl_q.gra;
    assign r_out   = ctl_q.r_out;
    assign con_in  = ctl_q.con_in;
    assign pc_next = pc_next_q;
    assign pc_load = pc_load_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign taken   = taken_q;

endmodule

// File: tb/tb_branch_seq.sv
// Directed bench for branch_seq with a condition flip-flop model and a
// scoreboard of expected branch outcomes.
module tb_branch_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [31:0] ir = '0;
    logic [31:0] pc = '0;
    logic        con_out;
    logic        cond_val = 1'b0;
    logic [3:0]  c2_sel;
    logic        gra, r_out, con_in, pc_load, busy, done, taken;
    logic [31:0] pc_next;

    typedef struct packed {
        logic        taken;
        logic [31:0] target;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;

    branch_seq #(.WIDTH(32), .OFF_W(19)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .ir      (ir),
        .pc      (pc),
        .con_out (con_out),
        .c2_sel  (c2_sel),
        .gra     (gra),
        .r_out   (r_out),
        .con_in  (con_in),
        .pc_next (pc_next),
        .pc_load (pc_load),
        .busy    (busy),
        .done    (done),
        .taken   (taken)
    );

    always #5 clk = ~clk;

    // Condition flip-flop: captures the evaluated condition on con_in.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)      con_out <= 1'b0;
        else if (con_in) con_out <= cond_val;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] tgt(input logic [31:0] p, input logic [18:0] d);
        return p + {{13{d[18]}}, d};
    endfunction

    // One branch; extra=1 pulses start in EVAL, extra=2 pulses it with done.
    task automatic branch(input logic [31:0] p, input logic [3:0] c2,
                          input logic [18:0] d, input logic c, input int extra);
        exp_t e;
        exp_t got;
        int   n;
        @(negedge clk);
        pc       = p;
        ir       = {9'h15A, c2, d};
        cond_val = c;
        start    = 1'b1;
        e.taken  = c;
        e.target = tgt(p, d);
        sb.push_back(e);

        @(negedge clk);
        start = 1'b0;
        pc    = 32'hDEAD_BEEF;
        ir    = '1;
        chk("drive_ctl", 32'({gra, r_out, con_in, busy}), 32'hF);
        chk("drive_c2", 32'(c2_sel), 32'(c2));
        chk("drive_out", 32'({done, pc_load, taken}), 32'h0);

        @(negedge clk);
        chk("eval_ctl", 32'({gra, r_out, con_in, pc_load, done}), 32'h0);
        chk("eval_busy", 32'(busy), 32'h1);
        chk("eval_pc_next", pc_next, e.target);
        if (extra == 1) start = 1'b1;

        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (!done && n < 6) begin
            @(negedge clk);
            n++;
        end
        chk("done_latency", 32'(n), 32'd1);
        chk("sb_nonempty", 32'(sb.size()), 32'd1);
        got = sb.pop_front();
        chk("done_taken", 32'(taken), 32'(got.taken));
        chk("done_pc_load", 32'(pc_load), 32'(got.taken));
        chk("done_busy", 32'(busy), 32'h1);
        if (got.taken) chk("done_target", pc_next, got.target);
        if (extra == 2) start = 1'b1;

        @(negedge clk);
        start = 1'b0;
        chk("post_idle", 32'({done, busy, pc_load, taken}), 32'h0);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1;
        chk("reset_ctl", 32'({gra, r_out, con_in, pc_load, busy, done, taken}), 32'h0);
        chk("reset_c2", 32'(c2_sel), 32'h0);
        chk("reset_pc_next", pc_next, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Forward taken, then same setup not taken.
        branch(32'h0000_0100, 4'd0, 19'h00010, 1'b1, 0);
        branch(32'h0000_0100, 4'd0, 19'h00010, 1'b0, 0);
        // Negative displacement wrapping below zero.
        branch(32'h0000_0002, 4'd3, 19'h7FFFC, 1'b1, 0);
        // Start while busy (EVAL) and start coincident with done are ignored.
        branch(32'h0000_2000, 4'd1, 19'h40000, 1'b0, 1);
        branch(32'h1234_5678, 4'd2, 19'h00004, 1'b1, 2);

        // Reset during EVAL aborts without loading the PC.
        @(negedge clk);
        pc       = 32'h0000_4000;
        ir       = {9'h0, 4'd0, 19'h00100};
        cond_val = 1'b1;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_ctl", 32'({gra, r_out, con_in, pc_load, busy, done, taken}), 32'h0);
        chk("abort_c2", 32'(c2_sel), 32'h0);
        chk("abort_pc_next", pc_next, 32'h0);
        @(negedge clk);
        chk("abort_held", 32'({pc_load, busy, done}), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_after", 32'({pc_load, busy, done}), 32'h0);

        // Fresh start after abort, then back-to-back sequences.
        branch(32'h0000_4000, 4'd0, 19'h00100, 1'b1, 0);
        branch(32'h8000_0000, 4'd5, 19'h3FFFF, 1'b0, 0);
        branch(32'hFFFF_FFF0, 4'd1, 19'h00020, 1'b1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
